// File: rtl/audio_tone_fx_if.sv
// Audio_Controller sample handshake bundle: ADC read side and DAC write side.
// The effect stage is the slave; the codec controller (or a bench) is the master.
interface audio_tone_fx_if #(
    parameter int DATA_W = 32
);
    logic                     in_available;
    logic signed [DATA_W-1:0] in_left;
    logic signed [DATA_W-1:0] in_right;
    logic                     read_in;
    logic                     out_allowed;
    logic signed [DATA_W-1:0] out_left;
    logic signed [DATA_W-1:0] out_right;
    logic                     write_out;

    modport master (
        output in_available, in_left, in_right, out_allowed,
        input  read_in, out_left, out_right, write_out
    );

    modport slave (
        input  in_available, in_left, in_right, out_allowed,
        output read_in, out_left, out_right, write_out
    );
endinterface

// File: rtl/audio_tone_fx.sv
// Audio effect stage: pass / chop / tone / saturating tone-mix on each sample pair,
// with a one-entry buffer between the ADC pop and the DAC push.
module audio_tone_fx #(
    parameter int DATA_W   = 32,
    parameter int PERIOD_W = 19,
    parameter int TONE_AMP = 10000000
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic [1:0]          cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_half_period,
    audio_tone_fx_if.slave      aud,
    output logic                tone_phase,
    output logic                busy
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic signed [DATA_W-1:0] AMP_P   = DATA_W'(TONE_AMP);
    localparam logic signed [DATA_W-1:0] AMP_N   = -AMP_P;
    localparam logic signed [DATA_W-1:0] S_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] S_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] S_ZERO  = {DATA_W{1'b0}};
    localparam logic [PERIOD_W-1:0]      CNT_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_W-1:0]      CNT_ZERO = {PERIOD_W{1'b0}};

    state_t                   state_r;
    logic [PERIOD_W-1:0]      cnt_r;
    logic                     tone_phase_r;
    logic                     read_in_r;
    logic                     write_out_r;
    logic                     busy_r;
    logic signed [DATA_W-1:0] out_left_r;
    logic signed [DATA_W-1:0] out_right_r;

    logic                     tone_en_s;
    logic signed [DATA_W-1:0] tone_s;
    logic signed [DATA_W-1:0] proc_left_s;
    logic signed [DATA_W-1:0] proc_right_s;

    // Sum at DATA_W+1 bits; disagreeing top two bits mean the result left the range.
    function automatic logic signed [DATA_W-1:0] sat_add(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic [DATA_W:0] sum;
        sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (sum[DATA_W] != sum[DATA_W-1]) begin
            sat_add = sum[DATA_W] ? S_MIN : S_MAX;
        end else begin
            sat_add = sum[DATA_W-1:0];
        end
    endfunction

    function automatic logic signed [DATA_W-1:0] fx(
        input logic [1:0]               mode,
        input logic signed [DATA_W-1:0] x,
        input logic signed [DATA_W-1:0] tone,
        input logic                     en,
        input logic                     phase
    );
        case (mode)
            2'd0:    fx = x;
            2'd1:    fx = phase ? S_ZERO : x;
            2'd2:    fx = en ? tone : S_ZERO;
            2'd3:    fx = en ? sat_add(x, tone) : x;
            default: fx = x;
        endcase
    endfunction

    // Effect result for the sample pair currently offered by the ADC side.
    always_comb begin
        tone_en_s    = (cfg_half_period != CNT_ZERO);
        tone_s       = tone_phase_r ? AMP_P : AMP_N;
        proc_left_s  = fx(cfg_mode, aud.in_left,  tone_s, tone_en_s, tone_phase_r);
        proc_right_s = fx(cfg_mode, aud.in_right, tone_s, tone_en_s, tone_phase_r);
    end

    // Square-wave generator; >= lets a shortened period wrap at once.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r        <= CNT_ZERO;
            tone_phase_r <= 1'b0;
        end else if (cfg_half_period == CNT_ZERO) begin
            cnt_r        <= CNT_ZERO;
            tone_phase_r <= 1'b0;
        end else if (cnt_r >= cfg_half_period) begin
            cnt_r        <= CNT_ZERO;
            tone_phase_r <= ~tone_phase_r;
        end else begin
            cnt_r        <= cnt_r + CNT_ONE;
            tone_phase_r <= tone_phase_r;
        end
    end

    // Buffer FSM. No decision is taken in a pulse cycle, so the codec FIFO
    // flags have a clock to settle after each pop or push.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_EMPTY;
            read_in_r   <= 1'b0;
            write_out_r <= 1'b0;
            busy_r      <= 1'b0;
            out_left_r  <= S_ZERO;
            out_right_r <= S_ZERO;
        end else begin
            read_in_r   <= 1'b0;
            write_out_r <= 1'b0;
            case (state_r)
                ST_EMPTY: begin
                    if (aud.in_available && !write_out_r) begin
                        read_in_r   <= 1'b1;
                        busy_r      <= 1'b1;
                        out_left_r  <= proc_left_s;
                        out_right_r <= proc_right_s;
                        state_r     <= ST_FULL;
                    end else begin
                        state_r <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (aud.out_allowed && !read_in_r) begin
                        write_out_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_EMPTY;
                    end else begin
                        state_r <= ST_FULL;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

    assign aud.read_in   = read_in_r;
    assign aud.write_out = write_out_r;
    assign aud.out_left  = out_left_r;
    assign aud.out_right = out_right_r;
    assign tone_phase    = tone_phase_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_audio_tone_fx.sv
// Directed bench for audio_tone_fx: tone timing, each effect mode, handshake
// pacing, back-pressure and reset while holding a sample.
module tb_audio_tone_fx;

    logic        clk;
    logic        reset_n;
    logic [1:0]  cfg_mode;
    logic [18:0] cfg_half_period;
    logic        tone_phase;
    logic        busy;
    int          total;
    int          bad;

    audio_tone_fx_if #(.DATA_W(32)) bus ();

    audio_tone_fx #(.DATA_W(32), .PERIOD_W(19), .TONE_AMP(10000000)) dut (
        .CLOCK_50        (clk),
        .reset_n         (reset_n),
        .cfg_mode        (cfg_mode),
        .cfg_half_period (cfg_half_period),
        .aud             (bus.slave),
        .tone_phase      (tone_phase),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Offer one sample pair from a negedge; returns the phase the DUT decides on.
    task automatic capture(output logic ok, output logic ph);
        ok = 1'b0;
        ph = tone_phase;
        bus.in_available = 1'b1;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (bus.read_in) ok = 1'b1;
        end
        bus.in_available = 1'b0;
    endtask

    task automatic drain(output logic ok, output logic [31:0] l, output logic [31:0] r);
        ok = 1'b0;
        l  = 32'h0;
        r  = 32'h0;
        bus.out_allowed = 1'b1;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (bus.write_out) begin
                ok = 1'b1;
                l  = bus.out_left;
                r  = bus.out_right;
            end
        end
        bus.out_allowed = 1'b0;
        @(negedge clk);
    endtask

    // Wait for a fresh transition into the wanted phase.
    task automatic wait_phase(input logic want, output logic ok);
        logic prev;
        ok   = 1'b0;
        prev = tone_phase;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            if (tone_phase == want && prev != want) ok = 1'b1;
            prev = tone_phase;
        end
    endtask

    task automatic test_reset;
        reset_n          = 1'b0;
        cfg_mode         = 2'd0;
        cfg_half_period  = 19'd3;
        bus.in_available = 1'b0;
        bus.out_allowed  = 1'b0;
        bus.in_left      = 32'h0;
        bus.in_right     = 32'h0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.read_in, bus.write_out, busy, tone_phase} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=0000", {bus.read_in, bus.write_out, busy, tone_phase});
        end
        total++;
        if ({bus.out_left, bus.out_right} !== 64'h0) begin
            bad++;
            $display("FAIL reset_outs got=%h want=0", {bus.out_left, bus.out_right});
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            total++;
            if (tone_phase !== 1'((k / 4) % 2)) begin
                bad++;
                $display("FAIL tone_hp3 k=%0d got=%b want=%b", k, tone_phase, 1'((k / 4) % 2));
            end
        end
        total++;
        if ({bus.read_in, bus.write_out, bus.out_left, bus.out_right} !== 66'h0) begin
            bad++;
            $display("FAIL idle_quiet got=%h want=0", {bus.read_in, bus.write_out, bus.out_left, bus.out_right});
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] want;
        cfg_mode         = 2'd0;
        bus.in_left      = 32'h12345678;
        bus.in_right     = 32'hFFFFFFFB;
        bus.in_available = 1'b1;
        bus.out_allowed  = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            want = {(k % 4) == 1, (k % 4) == 3};
            total++;
            if ({bus.read_in, bus.write_out} !== want) begin
                bad++;
                $display("FAIL b2b_pulses k=%0d got=%b want=%b", k, {bus.read_in, bus.write_out}, want);
            end
            if (bus.write_out) begin
                total++;
                if ({bus.out_left, bus.out_right} !== 64'h12345678_FFFFFFFB) begin
                    bad++;
                    $display("FAIL b2b_data k=%0d got=%h want=12345678fffffffb", k, {bus.out_left, bus.out_right});
                end
            end
        end
        bus.in_available = 1'b0;
        bus.out_allowed  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_chop;
        logic ok, ph;
        logic [31:0] l, r;
        cfg_mode        = 2'd1;
        cfg_half_period = 19'd1999;
        bus.in_left     = 32'h01020304;
        bus.in_right    = 32'hF0F0F0F0;
        for (int p = 1; p >= 0; p--) begin
            wait_phase(1'(p), ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL chop_wait p=%0d got=timeout want=phase", p);
            end
            capture(ok, ph);
            drain(ok, l, r);
            total++;
            if ({ok, ph} !== {1'b1, 1'(p)}) begin
                bad++;
                $display("FAIL chop_xfer p=%0d got=%b want=1%0d", p, {ok, ph}, p);
            end
            total++;
            if ({l, r} !== ((p == 1) ? 64'h0 : 64'h01020304_F0F0F0F0)) begin
                bad++;
                $display("FAIL chop_data p=%0d got=%h", p, {l, r});
            end
        end
    endtask

    task automatic test_mix;
        logic ok, ph;
        logic [31:0] l, r;
        cfg_mode     = 2'd3;
        bus.in_left  = 32'h7FFFFFF0;
        bus.in_right = 32'h80000005;
        for (int p = 1; p >= 0; p--) begin
            wait_phase(1'(p), ok);
            capture(ok, ph);
            drain(ok, l, r);
            total++;
            if ({ok, ph} !== {1'b1, 1'(p)}) begin
                bad++;
                $display("FAIL mix_xfer p=%0d got=%b want=1%0d", p, {ok, ph}, p);
            end
            total++;
            if ({l, r} !== ((p == 1) ? 64'h7FFFFFFF_80989685 : 64'h7F676970_80000000)) begin
                bad++;
                $display("FAIL mix_data p=%0d got=%h", p, {l, r});
            end
        end
    endtask

    task automatic test_tone;
        logic ok, ok2, ph;
        logic [31:0] l, r;
        cfg_mode        = 2'd2;
        cfg_half_period = 19'd0;
        bus.in_left     = 32'h11111111;
        bus.in_right    = 32'h22222222;
        for (int n = 0; n < 3; n++) begin
            capture(ok, ph);
            drain(ok2, l, r);
            total++;
            if ({ok, ok2, tone_phase, l, r} !== {2'b11, 1'b0, 64'h0}) begin
                bad++;
                $display("FAIL tone_off n=%0d got=%b/%h want=110/0", n, {ok, ok2, tone_phase}, {l, r});
            end
        end
        cfg_half_period = 19'd10;
        for (int p = 1; p >= 0; p--) begin
            wait_phase(1'(p), ok);
            capture(ok, ph);
            drain(ok2, l, r);
            total++;
            if ({ok, ok2, ph} !== {2'b11, 1'(p)}) begin
                bad++;
                $display("FAIL tone_xfer p=%0d got=%b", p, {ok, ok2, ph});
            end
            total++;
            if ({l, r} !== ((p == 1) ? 64'h00989680_00989680 : 64'hFF676980_FF676980)) begin
                bad++;
                $display("FAIL tone_data p=%0d got=%h", p, {l, r});
            end
        end
    endtask

    task automatic test_hold_reset;
        logic ok, ph;
        cfg_mode        = 2'd0;
        cfg_half_period = 19'd0;
        bus.in_left     = 32'h0BADF00D;
        bus.in_right    = 32'hFEEDFACE;
        capture(ok, ph);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL hold_capture got=%b want=1", ok);
        end
        bus.in_available = 1'b1;
        bus.in_left      = 32'h55555555;
        cfg_mode         = 2'd2;
        cfg_half_period  = 19'd5;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            total++;
            if ({bus.read_in, bus.write_out, busy, bus.out_left, bus.out_right} !== {3'b001, 64'h0BADF00D_FEEDFACE}) begin
                bad++;
                $display("FAIL hold k=%0d got=%b/%h want=001/0badf00dfeedface", k,
                         {bus.read_in, bus.write_out, busy}, {bus.out_left, bus.out_right});
            end
        end
        #5 reset_n = 1'b0;
        #1;
        total++;
        if ({busy, bus.write_out, bus.read_in, bus.out_left, bus.out_right} !== 67'h0) begin
            bad++;
            $display("FAIL hold_reset got=%b/%h want=0", {busy, bus.write_out, bus.read_in}, {bus.out_left, bus.out_right});
        end
        bus.in_available = 1'b0;
        bus.out_allowed  = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++;
            if ({bus.write_out, busy} !== 2'b00) begin
                bad++;
                $display("FAIL post_reset_write k=%0d got=%b want=00", k, {bus.write_out, busy});
            end
        end
        bus.out_allowed = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_back_to_back();
        test_chop();
        test_mix();
        test_tone();
        test_hold_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_tone_fx.md
Name: audio_tone_fx

Overview:
- Parametrised audio effect stage between the Audio_Controller read-side handshake (audio_in_available / read_audio_in) and its write-side handshake (audio_out_allowed / write_audio_out).
- Generalises the fixed switch-driven chopper into four runtime-selectable modes: passthrough, chop, tone-only and saturating tone mix.
- Has a configurable tone half-period and amplitude, and a one-entry sample buffer with an explicit read/write FSM.
- The top level wires SW/KEY into the cfg_* ports.

Parameters:
- DATA_W, 32, signed sample width per channel.
- PERIOD_W, 19, width of the tone half-period counter and of cfg_half_period.
- TONE_AMP, 10000000, magnitude of the generated square wave (must be < 2^(DATA_W-1)).

Ports:
- CLOCK_50  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_mode  in  2  mode: 0 = pass, 1 = chop, 2 = tone, 3 = mix.
- cfg_half_period  in  PERIOD_W  tone half-period minus 1, in clocks; 0 = tone disabled.
- in_available  in  1  Audio_Controller has an ADC sample pair.
- in_left  in  DATA_W  left ADC sample; valid while in_available.
- in_right  in  DATA_W  right ADC sample; valid while in_available.
- read_in  out  1  one-cycle pop of the ADC sample pair.
- out_allowed  in  1  DAC FIFO has space.
- out_left  out  DATA_W  processed left sample; held stable while FULL.
- out_right  out  DATA_W  processed right sample.
- write_out  out  1  one-cycle push of out_left/out_right.
- tone_phase  out  1  current square-wave phase.
- busy  out  1  buffer holds an unwritten sample.

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to EMPTY.
  - read_in, write_out, busy, tone_phase = 0.
  - out_left and out_right = 0.
  - tone counter = 0.
  - Any buffered sample is discarded.
- Tone generator:
  - Counter cnt[PERIOD_W-1:0].
  - If cfg_half_period == 0: cnt is held at 0 and tone_phase is forced to 0 (tone disabled).
  - Else if cnt >= cfg_half_period: cnt <= 0 and tone_phase toggles.
  - Else cnt increments.
  - Full period is therefore 2*(cfg_half_period+1) clocks.
  - The >= compare means that lowering the period mid-count wraps on the next cycle. The counter never runs to 2^PERIOD_W.
- tone = tone_phase ? +TONE_AMP : -TONE_AMP, sign-extended to DATA_W.
- Processing, per channel, evaluated in the capture cycle:
  - Mode 0: x.
  - Mode 1: tone_phase ? 0 : x.
  - Mode 2: tone, or 0 when the tone is disabled.
  - Mode 3: sat(x + tone), or x when the tone is disabled.
- Saturation:
  - The sum is computed at DATA_W+1 bits.
  - It clamps to +(2^(DATA_W-1)-1) or -2^(DATA_W-1) on overflow.
- FSM states:
  - EMPTY: if in_available, then read_in = 1 for exactly this cycle, the processed result is registered into out_left/out_right, and the FSM goes to FULL.
  - FULL: busy = 1 and read_in = 0. If out_allowed, then write_out = 1 for exactly this cycle and the FSM goes to EMPTY. Otherwise it stays in FULL, holding the data.
- read_in and write_out are registered outputs:
  - read_in asserts the cycle after in_available is seen in EMPTY.
  - Capture uses the in_* values and the cfg/tone_phase values sampled in that same decision cycle.
  - write_out asserts the cycle after out_allowed is seen in FULL.
- read_in and write_out are never high in the same cycle.
- Throughput:
  - Minimum 4 clocks per sample pair: decide, read, decide, write.
  - This is far below the 48 kHz rate.
- Samples are consumed in all modes, including tone-only, so the ADC FIFO never overflows.
- cfg_mode or cfg_half_period changes while FULL do not alter the held sample. They take effect from the next capture.
- Simultaneous in_available and out_allowed:
  - In EMPTY, only the read is acted on.
  - In FULL, only the write is acted on.
- out_allowed falling while FULL: data is held indefinitely, no sample is lost, and read_in stays 0 (back-pressure).
- Reset asserted mid-FULL: the held sample is dropped and write_out is not issued.

Test Plan:
- Reset, then release with cfg_half_period = 3 and inputs idle -> tone_phase toggles every 4 clocks; read_in = write_out = 0; outs = 0.
- Mode 0, in_left = 0x12345678, in_right = -5, in_available = 1, out_allowed = 1 -> exactly one read_in pulse, then one write_out pulse carrying the identical values, then repeat.
- Mode 1, cfg_half_period = 1999: capture with tone_phase = 1 -> outs = 0. Capture with tone_phase = 0 -> outs = inputs.
- Mode 3, in_left = 0x7FFFFFF0, in_right = 0x80000005:
  - Phase 1: left saturates to 0x7FFFFFFF; right = 0x80989685.
  - Phase 0: right saturates to 0x80000000.
- Mode 2 with cfg_half_period = 0 -> outs = 0 while samples are still consumed at the input rate. Set cfg_half_period = 10 -> outs alternate ±10000000.
- FULL with out_allowed low for 50 clocks while in_available is high -> no read_in, held data unchanged. Assert reset_n = 0 mid-hold -> busy = 0 and outs = 0 immediately, no write_out.
